motor_cmd_ramp: RTL and testbench
=================================

Name: motor_cmd_ramp

Overview:
- Command-conditioning stage directly upstream of the per-motor PWM generator. Its duty_out drives the generator's 8-bit x_in.
- Accepts throttle commands over a valid/ready handshake and gates them through an arm/disarm state machine.
- Slew-limits duty changes and applies them only at 256-clock PWM period boundaries, so the generator never sees a mid-period change.
- Forces a controlled ramp to zero when commands stop arriving.

Parameters:
- WIDTH, 8, duty/command width; equals the PWM generator input width.
- STEP, 4, maximum duty change per PWM period, up or down.
- MAX_DUTY, 255, ceiling applied to accepted commands.
- ARM_PERIODS, 16, periods arm_in must stay high with duty 0 before commands are accepted.
- TIMEOUT_PERIODS, 64, periods without an accepted command before entering FAILSAFE.

Ports:
- clk_in, input, 1, system clock; same clock as the PWM generator.
- rst_n_in, input, 1, reset, synchronous, active-low.
- arm_in, input, 1, arm request level from flight controller.
- cmd_in, input, WIDTH, requested duty.
- cmd_valid_in, input, 1, cmd_in is valid.
- cmd_ready_out, output, 1, block accepts cmd_in this cycle.
- duty_out, output, WIDTH, registered duty to the PWM generator x_in.
- period_start_out, output, 1, one-cycle pulse on the first cycle of each PWM period.
- armed_out, output, 1, high in ARMED.
- failsafe_out, output, 1, high in FAILSAFE.

Behaviour:
- Reset (rst_n_in low at a clk_in edge): state DISARMED, duty_out=0, target=0, period counter=0, timeout counter=0, cmd_ready_out=0, period_start_out=0, armed_out=0, failsafe_out=0. Reset takes effect mid-ramp or mid-handshake with no completion of the pending transfer.
- Period counter: 8 bits, free-running 0..255, wraps to 0. The boundary is the edge where it goes 255->0. period_start_out is registered high for the cycle in which the counter equals 0.
- Handshake: cmd_ready_out=1 only in ARMED. A transfer occurs when cmd_valid_in && cmd_ready_out; target <= min(cmd_in, MAX_DUTY). A transfer on the boundary cycle is not used by that boundary's ramp step; it first affects the next boundary.
- Ramp, at each boundary edge:
  - if duty<target: duty <= min(duty+STEP, target)
  - if duty>target: duty <= max(duty-STEP, target)
  - arithmetic uses WIDTH+1 bits, with no wrap at 0 or 255.
  - duty_out changes only on boundary edges, except for the forced-zero case below.
- Timeout counter: counts boundaries since the last transfer; cleared on a transfer. If a transfer and the TIMEOUT_PERIODS-th boundary fall in the same cycle, the transfer wins.
- States:
  - DISARMED: duty_out forced 0, target 0. If arm_in=1, go to ARMING and clear the arm counter.
  - ARMING: duty_out 0. Count boundaries; on reaching ARM_PERIODS, go to ARMED with target 0 and the timeout counter cleared.
  - ARMED: normal ramping. On the timeout counter reaching TIMEOUT_PERIODS, go to FAILSAFE.
  - FAILSAFE: target forced 0, ramps down by STEP per boundary, cmd_ready_out=0. Stays until arm_in=0; a recovered command stream does not exit FAILSAFE.
- Disarm override: arm_in=0 in any state -> DISARMED on the next edge; duty_out=0 on that same edge without waiting for a boundary. This has priority over every other transition.
- armed_out and failsafe_out are registered and decoded from the state; they change on the same edge as the state.

Decomposition:
- Shared package holds:
  - state enum {DISARMED, ARMING, ARMED, FAILSAFE}
  - PWM_PERIOD_BITS=8
  - default STEP/ARM_PERIODS/TIMEOUT_PERIODS constants, reused by the motor mixer and top level.
- One natural sub-module: pwm_period_timer (the 8-bit wrap counter plus the period_start_out strobe). It is shared so that several motor channels can run off one timer instance.

Test Plan:
- Reset: hold rst_n_in low 3 cycles with arm_in=1 and cmd_valid_in=1 -> all outputs 0 and cmd_ready_out=0; after release, ARMING.
- Arming: arm_in=1 from reset -> armed_out rises after exactly 16 boundaries (16*256 cycles, ±1 alignment cycle); duty_out stays 0 throughout.
- Ramp up, then clamp: with MAX_DUTY=200, send cmd=10 -> duty 4, 8, 10 on successive boundaries. Then send cmd=255 -> target clamped to 200; duty reaches 200 after 48 boundaries and never exceeds it.
- Boundary race: assert a transfer of cmd=100 on the period_start cycle while duty=target=0 -> that boundary keeps duty 0; the next boundary gives duty 4.
- Timeout: with duty=40, stop commands -> failsafe_out rises at the 64th boundary; duty falls 36, 32, ... to 0 over 10 boundaries; cmd_ready_out=0; a new command is not accepted.
- Disarm override: with duty=120 mid-period, drop arm_in -> duty_out=0 and armed_out=0 on the next edge, without waiting for a boundary; re-arming requires a fresh 16-period ARMING.

Source files
------------

// File: rtl/motor_cmd_ramp_pkg.sv
// rtl/motor_cmd_ramp_pkg.sv - shared motor command types and default ramp constants
package motor_cmd_ramp_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMING   = 2'd1,
        ARMED    = 2'd2,
        FAILSAFE = 2'd3
    } motor_state_t;

    localparam int PWM_PERIOD_BITS         = 8;
    localparam int DEFAULT_STEP            = 4;
    localparam int DEFAULT_ARM_PERIODS     = 16;
    localparam int DEFAULT_TIMEOUT_PERIODS = 64;

endpackage

// File: rtl/pwm_period_timer.sv
// rtl/pwm_period_timer.sv - free-running PWM period counter with period-start strobe
module pwm_period_timer
    import motor_cmd_ramp_pkg::*;
(
    input  logic clk_in,
    input  logic rst_n_in,
    output logic boundary_out,
    output logic period_start_out
);

    logic [PWM_PERIOD_BITS-1:0] count_q;

    // High in the last cycle of a period: the next edge wraps the counter to 0.
    assign boundary_out = (count_q == {PWM_PERIOD_BITS{1'b1}});

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            count_q          <= '0;
            period_start_out <= 1'b0;
        end else begin
            count_q          <= count_q + PWM_PERIOD_BITS'(1);
            period_start_out <= boundary_out;
        end
    end

endmodule

// File: rtl/motor_cmd_ramp.sv
// rtl/motor_cmd_ramp.sv - armed, slew-limited, period-aligned duty command stage
module motor_cmd_ramp
    import motor_cmd_ramp_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int STEP            = DEFAULT_STEP,
    parameter int MAX_DUTY        = 255,
    parameter int ARM_PERIODS     = DEFAULT_ARM_PERIODS,
    parameter int TIMEOUT_PERIODS = DEFAULT_TIMEOUT_PERIODS
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             arm_in,
    input  logic [WIDTH-1:0] cmd_in,
    input  logic             cmd_valid_in,
    output logic             cmd_ready_out,
    output logic [WIDTH-1:0] duty_out,
    output logic             period_start_out,
    output logic             armed_out,
    output logic             failsafe_out
);

    localparam int ARM_W = $clog2(ARM_PERIODS + 1);
    localparam int TMO_W = $clog2(TIMEOUT_PERIODS + 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_PERIODS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_PERIODS - 1);
    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH + 1)'(MAX_DUTY);

    motor_state_t     state_q, state_d;
    logic [WIDTH-1:0] duty_q, duty_d, target_q, target_d;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             boundary;
    logic             transfer;
    logic [WIDTH-1:0] cmd_clamped;
    logic [WIDTH-1:0] ramp_next;
    logic [WIDTH:0]   duty_ext, target_ext, up_sum;

    pwm_period_timer u_timer (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .boundary_out     (boundary),
        .period_start_out (period_start_out)
    );

    assign transfer    = cmd_valid_in && cmd_ready_out;
    assign cmd_clamped = ({1'b0, cmd_in} > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : cmd_in;

    // One slew step toward the target, computed one bit wider so nothing wraps.
    always_comb begin
        duty_ext   = {1'b0, duty_q};
        target_ext = {1'b0, target_q};
        up_sum     = duty_ext + STEP_EXT;
        ramp_next  = duty_q;
        if (duty_ext < target_ext) begin
            ramp_next = (up_sum > target_ext) ? target_q : up_sum[WIDTH-1:0];
        end else if (duty_ext > target_ext) begin
            ramp_next = (duty_ext > target_ext + STEP_EXT) ? duty_q - WIDTH'(STEP) : target_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        target_d  = target_q;
        arm_cnt_d = arm_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        if (!arm_in) begin
            state_d  = DISARMED;
            duty_d   = '0;
            target_d = '0;
        end else begin
            case (state_q)
                DISARMED: begin
                    duty_d    = '0;
                    target_d  = '0;
                    arm_cnt_d = '0;
                    state_d   = ARMING;
                end
                ARMING: begin
                    duty_d   = '0;
                    target_d = '0;
                    if (boundary) begin
                        if (arm_cnt_q == ARM_LAST) begin
                            state_d   = ARMED;
                            tmo_cnt_d = '0;
                        end else begin
                            arm_cnt_d = arm_cnt_q + ARM_W'(1);
                        end
                    end
                end
                ARMED: begin
                    if (boundary) duty_d = ramp_next;
                    if (transfer) begin
                        target_d  = cmd_clamped;
                        tmo_cnt_d = '0;
                    end else if (boundary) begin
                        if (tmo_cnt_q == TMO_LAST) begin
                            state_d  = FAILSAFE;
                            target_d = '0;
                        end else begin
                            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                        end
                    end
                end
                FAILSAFE: begin
                    target_d = '0;
                    if (boundary) duty_d = ramp_next;
                end
                default: begin
                    state_d  = DISARMED;
                    duty_d   = '0;
                    target_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q       <= DISARMED;
            duty_q        <= '0;
            target_q      <= '0;
            arm_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            cmd_ready_out <= 1'b0;
            armed_out     <= 1'b0;
            failsafe_out  <= 1'b0;
        end else begin
            state_q       <= state_d;
            duty_q        <= duty_d;
            target_q      <= target_d;
            arm_cnt_q     <= arm_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            cmd_ready_out <= (state_d == ARMED);
            armed_out     <= (state_d == ARMED);
            failsafe_out  <= (state_d == FAILSAFE);
        end
    end

    assign duty_out = duty_q;

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// tb/tb_motor_cmd_ramp.sv - directed self-checking bench for motor_cmd_ramp
module tb_motor_cmd_ramp;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       arm_in;
    logic [7:0] cmd_in;
    logic       cmd_valid_in;
    logic       cmd_ready_out;
    logic [7:0] duty_out;
    logic       period_start_out;
    logic       armed_out;
    logic       failsafe_out;

    int tests = 0;
    int fails = 0;

    motor_cmd_ramp #(.MAX_DUTY(200)) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .arm_in           (arm_in),
        .cmd_in           (cmd_in),
        .cmd_valid_in     (cmd_valid_in),
        .cmd_ready_out    (cmd_ready_out),
        .duty_out         (duty_out),
        .period_start_out (period_start_out),
        .armed_out        (armed_out),
        .failsafe_out     (failsafe_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Advance to the first cycle of the next PWM period.
    task automatic next_boundary();
        int n = 0;
        tick();
        n++;
        while (!period_start_out && n < 300) begin
            tick();
            n++;
        end
        if (!period_start_out) begin
            tests++;
            fails++;
            $display("FAIL next_boundary: period_start not seen in %0d cycles, required within 256", n);
        end
    endtask

    task automatic send_cmd(input logic [7:0] value);
        cmd_in       = value;
        cmd_valid_in = 1'b1;
        tick();
        cmd_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_in     = 1'b0;
        arm_in       = 1'b1;
        cmd_valid_in = 1'b1;
        cmd_in       = 8'd50;
        repeat (3) tick();
        tests++; if (duty_out !== 8'd0) begin fails++; $display("FAIL reset_duty: got %0d required 0", duty_out); end
        tests++; if (cmd_ready_out !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b required 0", cmd_ready_out); end
        tests++; if (period_start_out !== 1'b0) begin fails++; $display("FAIL reset_period_start: got %b required 0", period_start_out); end
        tests++; if (armed_out !== 1'b0) begin fails++; $display("FAIL reset_armed: got %b required 0", armed_out); end
        tests++; if (failsafe_out !== 1'b0) begin fails++; $display("FAIL reset_failsafe: got %b required 0", failsafe_out); end
    endtask

    task automatic test_arming();
        int  cycles = 0;
        bit  duty_seen = 1'b0;
        rst_n_in     = 1'b1;
        cmd_valid_in = 1'b0;
        while (!armed_out && cycles < 5000) begin
            tick();
            cycles++;
            if (duty_out !== 8'd0) duty_seen = 1'b1;
        end
        tests++; if (cycles < 4095 || cycles > 4097) begin fails++; $display("FAIL arm_latency: got %0d cycles required 4096", cycles); end
        tests++; if (duty_seen) begin fails++; $display("FAIL arm_duty_zero: got nonzero duty required 0"); end
        tests++; if (period_start_out !== 1'b1) begin fails++; $display("FAIL arm_on_boundary: got %b required 1", period_start_out); end
        tests++; if (cmd_ready_out !== 1'b1) begin fails++; $display("FAIL arm_ready: got %b required 1", cmd_ready_out); end
    endtask

    task automatic test_boundary_race();
        send_cmd(8'd100);
        tests++; if (duty_out !== 8'd0) begin fails++; $display("FAIL race_ps_hold: got %0d required 0", duty_out); end
        next_boundary();
        tests++; if (duty_out !== 8'd4) begin fails++; $display("FAIL race_ps_next: got %0d required 4", duty_out); end
        // Transfer in the last cycle of a period: this boundary still uses target 100.
        repeat (255) tick();
        send_cmd(8'd10);
        tests++; if (period_start_out !== 1'b1 || duty_out !== 8'd8) begin
            fails++; $display("FAIL race_last_cycle: got ps=%b duty=%0d required ps=1 duty=8", period_start_out, duty_out);
        end
    endtask

    task automatic test_ramp_clamp();
        int exp_duty;
        next_boundary();
        tests++; if (duty_out !== 8'd10) begin fails++; $display("FAIL ramp_to_10: got %0d required 10", duty_out); end
        next_boundary();
        tests++; if (duty_out !== 8'd10) begin fails++; $display("FAIL ramp_hold_10: got %0d required 10", duty_out); end
        send_cmd(8'd255);
        for (int k = 1; k <= 49; k++) begin
            next_boundary();
            exp_duty = (10 + 4 * k > 200) ? 200 : 10 + 4 * k;
            tests++; if (duty_out !== 8'(exp_duty)) begin
                fails++; $display("FAIL ramp_clamp k=%0d: got %0d required %0d", k, duty_out, exp_duty);
            end
        end
    endtask

    task automatic test_timeout();
        int exp_duty;
        bit exp_fs;
        send_cmd(8'd40);
        for (int k = 1; k <= 74; k++) begin
            next_boundary();
            exp_duty = (k <= 40) ? 200 - 4 * k : (k <= 64) ? 40 : 40 - 4 * (k - 64);
            exp_fs   = (k >= 64);
            tests++; if (duty_out !== 8'(exp_duty) || failsafe_out !== exp_fs) begin
                fails++; $display("FAIL timeout k=%0d: got duty=%0d fs=%b required duty=%0d fs=%b", k, duty_out, failsafe_out, exp_duty, exp_fs);
            end
            if (k == 64) begin
                tests++; if (cmd_ready_out !== 1'b0 || armed_out !== 1'b0) begin
                    fails++; $display("FAIL failsafe_flags: got ready=%b armed=%b required 0 0", cmd_ready_out, armed_out);
                end
            end
        end
        cmd_in       = 8'd200;
        cmd_valid_in = 1'b1;
        next_boundary();
        next_boundary();
        cmd_valid_in = 1'b0;
        tests++; if (duty_out !== 8'd0 || failsafe_out !== 1'b1) begin
            fails++; $display("FAIL failsafe_sticky: got duty=%0d fs=%b required duty=0 fs=1", duty_out, failsafe_out);
        end
    endtask

    task automatic test_disarm_override();
        int cycles = 0;
        int ps_cnt = 0;
        arm_in = 1'b0;
        tick();
        tests++; if (failsafe_out !== 1'b0) begin fails++; $display("FAIL failsafe_exit: got %b required 0", failsafe_out); end
        arm_in = 1'b1;
        while (!armed_out && cycles < 5000) begin
            tick();
            cycles++;
        end
        tests++; if (armed_out !== 1'b1) begin fails++; $display("FAIL rearm_1: got %b required 1", armed_out); end
        send_cmd(8'd120);
        for (int k = 1; k <= 30; k++) next_boundary();
        repeat (100) tick();
        tests++; if (duty_out !== 8'd120) begin fails++; $display("FAIL disarm_pre_duty: got %0d required 120", duty_out); end
        arm_in = 1'b0;
        tick();
        tests++; if (duty_out !== 8'd0 || armed_out !== 1'b0 || cmd_ready_out !== 1'b0 || period_start_out !== 1'b0) begin
            fails++; $display("FAIL disarm_immediate: got duty=%0d armed=%b ready=%b ps=%b required 0 0 0 0", duty_out, armed_out, cmd_ready_out, period_start_out);
        end
        arm_in = 1'b1;
        cycles = 0;
        while (!armed_out && cycles < 5000) begin
            tick();
            cycles++;
            if (period_start_out) ps_cnt++;
        end
        tests++; if (ps_cnt !== 16 || period_start_out !== 1'b1) begin
            fails++; $display("FAIL rearm_periods: got %0d boundaries ps=%b required 16 ps=1", ps_cnt, period_start_out);
        end
    endtask

    initial begin
        test_reset();
        test_arming();
        test_boundary_race();
        test_ramp_clamp();
        test_timeout();
        test_disarm_override();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
